rf_writeback_queue: RTL and testbench

- Buffers register-file write requests from the execute/load stages and drains them into the register file write port, one per cycle.
- Drives the register file's write_enable, write_addr and write_data inputs.
- Gives the decode stage a forwarding lookup, so pending, not-yet-written values are visible before they reach the register file.
- Absorbs bursts while the register file write port is held off (drain_hold).

---
 rtl/rf_writeback_queue_if.sv | 38 +++
 rtl/rf_writeback_queue.sv | 133 +++++++++++++
 tb/tb_rf_writeback_queue.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_writeback_queue_if.sv
// Bundle of producer, register-file write, forwarding-lookup and status signals
// for rf_writeback_queue. The queue uses the slave modport; the driver side uses master.
interface rf_writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              drain_hold;
    logic              write_enable;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] look_addr_1;
    logic [ADDR_W-1:0] look_addr_2;
    logic              look_hit_1;
    logic              look_hit_2;
    logic [DATA_W-1:0] look_data_1;
    logic [DATA_W-1:0] look_data_2;
    logic [CNT_W-1:0]  count;
    logic              empty;

    modport master (
        output in_valid, in_addr, in_data, drain_hold, look_addr_1, look_addr_2,
        input  in_ready, write_enable, write_addr, write_data,
               look_hit_1, look_hit_2, look_data_1, look_data_2, count, empty
    );

    modport slave (
        input  in_valid, in_addr, in_data, drain_hold, look_addr_1, look_addr_2,
        output in_ready, write_enable, write_addr, write_data,
               look_hit_1, look_hit_2, look_data_1, look_data_2, count, empty
    );
endinterface

// File: rtl/rf_writeback_queue.sv
// Register-file write-back FIFO with a combinational forwarding lookup for decode.
// Optional forwarding comparators are built only when RF_WBQ_FORWARD_EN is defined.
module rf_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_writeback_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic in_ready;
    logic empty;
    logic push;
    logic pop;

    // Readiness depends on registered occupancy only, never on this cycle's pop.
    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign push     = bus.in_valid && in_ready && (bus.in_addr != '0);
    assign pop      = !empty && !bus.drain_hold;

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            addr_d[wr_ptr_q]  = bus.in_addr;
            data_d[wr_ptr_q]  = bus.in_data;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.empty        = empty;
    assign bus.count        = count_q;
    assign bus.write_enable = pop;
    assign bus.write_addr   = empty ? '0 : addr_q[rd_ptr_q];
    assign bus.write_data   = empty ? '0 : data_q[rd_ptr_q];

`ifdef RF_WBQ_FORWARD_EN
    logic [DEPTH-1:0] match_1;
    logic [DEPTH-1:0] match_2;

    // Address 0 is the hardwired-zero register and never forwards.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign match_1[gi] = valid_q[gi] && (addr_q[gi] == bus.look_addr_1) && (bus.look_addr_1 != '0);
        assign match_2[gi] = valid_q[gi] && (addr_q[gi] == bus.look_addr_2) && (bus.look_addr_2 != '0);
    end

    logic              hit_1, hit_2;
    logic [DATA_W-1:0] fwd_1, fwd_2;
    logic [PTR_W-1:0]  scan_idx;

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit_1    = 1'b0;
        hit_2    = 1'b0;
        fwd_1    = '0;
        fwd_2    = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr_q + PTR_W'(k);
            if (match_1[scan_idx]) begin
                hit_1 = 1'b1;
                fwd_1 = data_q[scan_idx];
            end
            if (match_2[scan_idx]) begin
                hit_2 = 1'b1;
                fwd_2 = data_q[scan_idx];
            end
        end
    end

    assign bus.look_hit_1  = hit_1;
    assign bus.look_hit_2  = hit_2;
    assign bus.look_data_1 = fwd_1;
    assign bus.look_data_2 = fwd_2;
`else
    // Lookup ports stay in the port list; decode must stall on pending matches instead.
    logic unused_look;
    assign unused_look     = ^{bus.look_addr_1, bus.look_addr_2};
    assign bus.look_hit_1  = 1'b0;
    assign bus.look_hit_2  = 1'b0;
    assign bus.look_data_1 = '0;
    assign bus.look_data_2 = '0;
`endif
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Scoreboard bench for rf_writeback_queue: stimulus queues expected commits,
// a negedge monitor checks every register-file write against them.
module tb_rf_writeback_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
`ifdef RF_WBQ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_writeback_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rf_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_commits = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; completes one handshake at the next edge.
    task automatic push1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        if (a != '0) exp_q.push_back({a, d});
        $display("push addr=%0d data=0x%02h", a, d);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 20; i++) begin
            if (bus.empty) break;
            step();
        end
        check("drain_timeout_empty", 32'(bus.empty), 32'd1);
    endtask

    // Monitor: every cycle with write_enable high commits at the coming edge.
    always @(negedge clk) begin
        if (!rst && bus.write_enable) begin
            logic [ADDR_W+DATA_W-1:0] e;
            n_commits++;
            $display("commit addr=%0d data=0x%02h", bus.write_addr, bus.write_data);
            if (exp_q.size() == 0) begin
                check("unexpected_commit", 32'(bus.write_addr), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("commit_addr", 32'(bus.write_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                check("commit_data", 32'(bus.write_data), 32'(e[DATA_W-1:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_addr     = '0;
        bus.in_data     = '0;
        bus.drain_hold  = 1'b0;
        bus.look_addr_1 = '0;
        bus.look_addr_2 = '0;
        #2;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_we", 32'(bus.write_enable), 32'd0);
        check("rst_waddr", 32'(bus.write_addr), 32'd0);
        check("rst_wdata", 32'(bus.write_data), 32'd0);
        check("rst_hit1", 32'(bus.look_hit_1), 32'd0);
        check("rst_hit2", 32'(bus.look_hit_2), 32'd0);
        check("rst_ldata1", 32'(bus.look_data_1), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Single push, no hold: visible at the head in the next cycle.
        push1(5'd5, 8'h3C);
        #1;
        check("single_we", 32'(bus.write_enable), 32'd1);
        check("single_waddr", 32'(bus.write_addr), 32'd5);
        check("single_wdata", 32'(bus.write_data), 32'h3C);
        step();
        check("single_empty_after", 32'(bus.empty), 32'd1);

        // Fill under hold, then drain in order.
        bus.drain_hold = 1'b1;
        push1(5'd1, 8'h11);
        push1(5'd2, 8'h22);
        push1(5'd3, 8'h33);
        push1(5'd4, 8'h44);
        check("full_count", 32'(bus.count), 32'd4);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_we", 32'(bus.write_enable), 32'd0);
        bus.drain_hold = 1'b0;
        #1;
        check("drain_we", 32'(bus.write_enable), 32'd1);
        check("drain_in_ready_before_pop", 32'(bus.in_ready), 32'd0);
        step();
        check("drain_in_ready_after_pop", 32'(bus.in_ready), 32'd1);
        check("drain_count_after_pop", 32'(bus.count), 32'd3);
        wait_empty();

        // Forwarding: youngest of two writes to r7 wins; x0 never hits.
        bus.drain_hold = 1'b1;
        push1(5'd7, 8'h01);
        push1(5'd7, 8'h02);
        bus.look_addr_1 = 5'd7;
        bus.look_addr_2 = 5'd0;
        #1;
        check("fwd_hit1_r7", 32'(bus.look_hit_1), FWD ? 32'd1 : 32'd0);
        check("fwd_data1_r7", 32'(bus.look_data_1), FWD ? 32'h02 : 32'd0);
        check("fwd_hit2_x0", 32'(bus.look_hit_2), 32'd0);
        bus.look_addr_2 = 5'd7;
        bus.look_addr_1 = 5'd9;
        bus.in_valid = 1'b1;
        bus.in_addr  = 5'd9;
        bus.in_data  = 8'h99;
        exp_q.push_back({5'd9, 8'h99});
        $display("push addr=9 data=0x99");
        #1;
        check("fwd_hit2_r7", 32'(bus.look_hit_2), FWD ? 32'd1 : 32'd0);
        check("fwd_data2_r7", 32'(bus.look_data_2), FWD ? 32'h02 : 32'd0);
        check("fwd_incoming_not_visible", 32'(bus.look_hit_1), 32'd0);
        check("fwd_miss_data", 32'(bus.look_data_1), 32'd0);
        step();
        bus.in_valid = 1'b0;
        #1;
        check("fwd_hit1_r9", 32'(bus.look_hit_1), FWD ? 32'd1 : 32'd0);
        check("fwd_data1_r9", 32'(bus.look_data_1), FWD ? 32'h99 : 32'd0);
        bus.look_addr_1 = '0;
        bus.look_addr_2 = '0;
        bus.drain_hold  = 1'b0;
        wait_empty();

        // Write to x0: handshake completes, nothing enqueued.
        bus.drain_hold = 1'b1;
        check("x0_in_ready", 32'(bus.in_ready), 32'd1);
        push1(5'd0, 8'hFF);
        check("x0_count", 32'(bus.count), 32'd0);
        check("x0_empty", 32'(bus.empty), 32'd1);
        bus.drain_hold = 1'b0;
        step();
        step();

        // Steady state: count held at 3 with push and pop every cycle across wrap.
        bus.drain_hold = 1'b1;
        push1(5'd1, 8'hA0);
        push1(5'd2, 8'hA1);
        push1(5'd3, 8'hA2);
        bus.drain_hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push1(5'(4 + i), 8'(i));
            check("wrap_count", 32'(bus.count), 32'd3);
        end
        wait_empty();

        // Asynchronous reset with entries pending discards them.
        bus.drain_hold = 1'b1;
        push1(5'd10, 8'h5A);
        push1(5'd11, 8'h5B);
        push1(5'd12, 8'h5C);
        bus.drain_hold = 1'b0;
        #1;
        check("prerst_we", 32'(bus.write_enable), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_we", 32'(bus.write_enable), 32'd0);
        check("midrst_count", 32'(bus.count), 32'd0);
        check("midrst_empty", 32'(bus.empty), 32'd1);
        exp_q.delete();
        step();
        rst = 1'b0;
        #1;
        check("postrst_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        step();
        check("postrst_we", 32'(bus.write_enable), 32'd0);

        check("total_commits", 32'(n_commits), 32'd21);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
